// File: rtl/lvds_capture_pkg.sv
// ============================================================================
// Module      : lvds_capture_pkg
// Description : Shared types and constants for the LVDS burst capture
//               front end: FSM state encoding, default preamble pattern and
//               the burst down-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lvds_capture_pkg;

  // Capture FSM states; explicit 2-bit encoding keeps the register width fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_CAPTURE = 2'd2
  } capture_state_t;

  // Default three-word preamble, first-received word in the MSBs.
  localparam logic [47:0] LVDS_PREAMBLE_DEFAULT = 48'hFFFF_FFFF_AAAA;

  // Width of the burst down-counter. A one-word burst still needs a 1-bit
  // counter so the register never collapses to zero width.
  function automatic int BURST_CNT_W(input int burst_len);
    int w;
    w = $clog2(burst_len);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/preamble_matcher.sv
// ============================================================================
// Module      : preamble_matcher
// Description : PRE_LEN-deep word shift register fed every cycle from the
//               deserialiser, with a combinational compare against the
//               preamble pattern. The oldest word sits in the MSBs so the
//               register lines up directly with the packed pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module preamble_matcher
  import lvds_capture_pkg::*;
#(
  parameter int                        DATA_W   = 16,
  parameter int                        PRE_LEN  = 3,
  parameter logic [PRE_LEN*DATA_W-1:0] PREAMBLE = LVDS_PREAMBLE_DEFAULT
) (
  input  logic              lvds_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pInput,
  output logic [DATA_W-1:0] sr0,
  output logic              match
);

  localparam int c_sr_w = PRE_LEN * DATA_W;

  // An all-zero pattern would match the reset contents of the shift register.
  if (PREAMBLE == '0) begin : g_bad_preamble
    $error("preamble_matcher: PREAMBLE must not be all-zero");
  end

  if (PRE_LEN < 1) begin : g_bad_pre_len
    $error("preamble_matcher: PRE_LEN must be at least 1");
  end

  logic [c_sr_w-1:0] sr_d;
  logic [c_sr_w-1:0] sr_q;

  // Next shift-register contents: newest word enters at the LSB end.
  if (PRE_LEN == 1) begin : g_single
    // Single-word preamble: the register is just the last received word.
    always_comb begin
      sr_d = pInput;
    end
  end else begin : g_multi
    // Multi-word preamble: drop the oldest word, append the newest.
    always_comb begin
      sr_d = {sr_q[c_sr_w-DATA_W-1:0], pInput};
    end
  end

  // Shift register loads every cycle regardless of capture state.
  always_ff @(posedge lvds_clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr0   = sr_q[DATA_W-1:0];
  assign match = (sr_q == PREAMBLE);

endmodule

`default_nettype wire

// File: rtl/lvds_burst_capture.sv
// ============================================================================
// Module      : lvds_burst_capture
// Description : LVDS pixel-burst capture front end. Hunts for a preamble in
//               the deserialised word stream, then writes the following
//               BURST_LEN words to the async FIFO write port. Supports
//               single-shot / continuous modes, abort, FIFO-full overflow
//               flagging and a completed-burst counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lvds_burst_capture
  import lvds_capture_pkg::*;
#(
  parameter int                        DATA_W      = 16,
  parameter int                        PRE_LEN     = 3,
  parameter logic [PRE_LEN*DATA_W-1:0] PREAMBLE    = LVDS_PREAMBLE_DEFAULT,
  parameter int                        BURST_LEN   = 16,
  parameter bit                        START_ARMED = 1'b1
) (
  input  logic              lvds_clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              continuous,
  input  logic [DATA_W-1:0] pInput,
  input  logic              full,
  output logic              wr,
  output logic [DATA_W-1:0] fifoIn,
  output logic              busy,
  output logic              burstDone,
  output logic              overflow,
  output logic [15:0]       burstCount
);

  localparam int                   c_cnt_w       = BURST_CNT_W(BURST_LEN);
  localparam logic [c_cnt_w-1:0]   c_cnt_load    = c_cnt_w'(BURST_LEN - 1);
  localparam capture_state_t       c_reset_state = START_ARMED ? ST_HUNT : ST_IDLE;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("lvds_burst_capture: BURST_LEN must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Preamble detection
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] sr0;
  logic              match;

  preamble_matcher #(
    .DATA_W   (DATA_W),
    .PRE_LEN  (PRE_LEN),
    .PREAMBLE (PREAMBLE)
  ) u_preamble_matcher (
    .lvds_clk (lvds_clk),
    .reset    (reset),
    .pInput   (pInput),
    .sr0      (sr0),
    .match    (match)
  );

  // --------------------------------------------------------------------------
  // FSM, burst counter and registered FIFO-side outputs
  // --------------------------------------------------------------------------
  capture_state_t      state_d,       state_q;
  logic [c_cnt_w-1:0]  cnt_d,         cnt_q;
  logic                wr_d,          wr_q;
  logic [DATA_W-1:0]   fifo_in_d,     fifo_in_q;
  logic                burst_done_d,  burst_done_q;
  logic                overflow_d,    overflow_q;
  logic [15:0]         burst_count_d, burst_count_q;

  // Next-state and next-output logic. Abort overrides everything, including
  // a coincident arm and the write slot of the current capture cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = 1'b0;
    fifo_in_d     = fifo_in_q;
    burst_done_d  = 1'b0;
    overflow_d    = overflow_q;
    burst_count_d = burst_count_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d    = ST_HUNT;
            overflow_d = 1'b0;
          end
        end

        ST_HUNT: begin
          if (match) begin
            state_d = ST_CAPTURE;
            cnt_d   = c_cnt_load;
          end
        end

        ST_CAPTURE: begin
          // A full FIFO drops this word but the slot still counts toward
          // the burst length; there is no retry.
          fifo_in_d = sr0;
          wr_d      = ~full;
          if (full) begin
            overflow_d = 1'b1;
          end
          if (cnt_q == '0) begin
            burst_done_d  = 1'b1;
            burst_count_d = burst_count_q + 16'd1;
            state_d       = continuous ? ST_HUNT : ST_IDLE;
          end else begin
            cnt_d = cnt_q - c_cnt_w'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge lvds_clk or posedge reset) begin
    if (reset) begin
      state_q       <= c_reset_state;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      fifo_in_q     <= '0;
      burst_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      fifo_in_q     <= fifo_in_d;
      burst_done_q  <= burst_done_d;
      overflow_q    <= overflow_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign wr         = wr_q;
  assign fifoIn     = fifo_in_q;
  assign busy       = (state_q != ST_IDLE);
  assign burstDone  = burst_done_q;
  assign overflow   = overflow_q;
  assign burstCount = burst_count_q;

endmodule

`default_nettype wire

// File: doc/lvds_burst_capture.md
# lvds_burst_capture

Parametrised LVDS pixel-burst capture front end in the `lvds_clk` domain. It scans the deserialised word stream for a configurable preamble and captures a fixed-length burst of words that follows it. Captured words go to the write side of the downstream async FIFO, which carries them into the 40 MHz domain. It adds single-shot and continuous modes, abort, FIFO-full overflow detection and a burst counter.

## Interface
Parameters:
- `DATA_W`, 16, pixel word width
- `PRE_LEN`, 3, preamble length in words (≥1)
- `PREAMBLE`, {16'hFFFF,16'hFFFF,16'hAAAA}, `PRE_LEN*DATA_W` packed pattern, first-received word in MSBs; must not be all-zero (elaboration assertion)
- `BURST_LEN`, 16, words captured per burst (≥1)
- `START_ARMED`, 1, 1 = leave reset in HUNT, 0 = leave reset in IDLE

Ports:
- `lvds_clk` in 1 sole clock
- `reset` in 1 asynchronous, active-high reset
- `arm` in 1 single-cycle pulse, already synchronised to `lvds_clk`
- `abort` in 1 single-cycle pulse, synchronised
- `continuous` in 1 mode: 1 = re-hunt after each burst, 0 = single-shot
- `pInput` in `DATA_W` deserialised word, one per cycle
- `full` in 1 FIFO write-side full
- `wr` out 1 FIFO write strobe (registered)
- `fifoIn` out `DATA_W` FIFO write data (registered)
- `busy` out 1 state ≠ IDLE
- `burstDone` out 1 one-cycle pulse, coincident with final write slot of a burst
- `overflow` out 1 sticky: a word was dropped because `full`=1
- `burstCount` out 16 completed bursts, wraps 16'hFFFF→0

## Operation
- Shift register `sr[PRE_LEN]` loads `pInput` every cycle in every state. `match` is asserted when `sr` equals `PREAMBLE`, oldest word compared against the MSBs.
- States: IDLE, HUNT, CAPTURE.
  - IDLE: `arm` → HUNT and clears `overflow`.
  - HUNT: `match` → CAPTURE and loads the down-counter with `BURST_LEN-1`.
  - CAPTURE: each cycle, `wr`/`fifoIn` are registered from `sr[0]`, and the counter decrements.
    - At counter 0, the next state is HUNT if `continuous`=1 and IDLE otherwise.
    - At counter 0, `burstCount` increments and `burstDone` is asserted alongside that slot's output.
- `match` is ignored in CAPTURE, so payload may contain the pattern.
- Counter width is `$clog2(BURST_LEN)` with a minimum of 1. Counter arithmetic never underflows.
- If `full`=1 in a CAPTURE cycle, that word is dropped (`wr`=0 in its output slot) and `overflow` is set. The burst still counts its full length; no retry.
- `abort` from any state → IDLE on the next edge. Remaining writes are suppressed and `burstCount` is unchanged. `abort` together with `arm` → abort wins.
- `arm` outside IDLE is ignored.
- `continuous` is sampled only at the final CAPTURE cycle.
- Reset (any time, including mid-burst): `wr`=0, `fifoIn`=0, `burstDone`=0, `overflow`=0, `burstCount`=0, `sr`=0, counter=0. State is HUNT if `START_ARMED`=1, else IDLE. `busy` follows the state.

## Timing
- A word on `pInput` in cycle k is written (`wr`=1, `fifoIn`=word) in cycle k+2.
- Preamble last word in cycle N → `match` in N+1 → first payload word is the one in cycle N+1, written in N+3. The last write is in N+2+`BURST_LEN`.
- Zero-gap back-to-back bursts are supported in continuous mode: a preamble starting the cycle after the last payload word is detected.
- `overflow`, `burstCount` and `busy` update on the same edge as the corresponding `wr` slot or state change.

## Structure
- Package `lvds_capture_pkg`: state enum typedef `capture_state_t`, default preamble constant `LVDS_PREAMBLE_DEFAULT`, and a `BURST_CNT_W` helper function.
- Sub-module `preamble_matcher` (params `DATA_W`, `PRE_LEN`, `PREAMBLE`; outputs `sr0` and `match`).
- Top module: FSM, counter and registered outputs. Instantiated in place of the inline capture logic ahead of `fifo_async_top`.

## Test plan
- Defaults, single-shot, after `arm`: FFFF,FFFF,AAAA,0x0001..0x0010 → 16 writes of 0x0001..0x0010. First write 3 cycles after AAAA; `burstDone` with 0x0010; `burstCount`=1; state IDLE.
- Continuous, two back-to-back preambles with zero gap → 32 writes, `burstCount`=2, `busy` stays 1.
- Payload containing FFFF,FFFF,AAAA → captured as data, no re-trigger; exactly 16 writes.
- `full`=1 for payload words 5–6 → 14 writes; `overflow`=1 until next `arm` in IDLE.
- `abort` after the 4th write → no further writes, state IDLE, `burstCount` unchanged. `arm`+`abort` in the same cycle → remains IDLE.
- `reset` asserted mid-burst → all outputs 0 asynchronously. With `START_ARMED`=1, the next preamble yields a full burst without `arm`.
